// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM with double-buffered period/compare/polarity/mode; outputs registered (1-cycle latency).
// No backpressure: loads always accepted, pending bank applied only at a period boundary.
module pwm_multi_gen #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          arr,
    input  logic [CHANNELS*WIDTH-1:0] ccr,
    input  logic [CHANNELS-1:0]       pol,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_end,
    output logic                      update_ack
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      down_q, down_d;
    logic [WIDTH-1:0]          arr_a_q, arr_a_d, arr_p_q, arr_p_d;
    logic [CHANNELS*WIDTH-1:0] ccr_a_q, ccr_a_d, ccr_p_q, ccr_p_d;
    logic [CHANNELS-1:0]       pol_a_q, pol_a_d, pol_p_q, pol_p_d;
    logic                      mode_a_q, mode_a_d, mode_p_q, mode_p_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_end_q, period_end_d;
    logic                      update_ack_q, update_ack_d;

    logic                      period_last;
    logic                      transfer;
    logic [CHANNELS-1:0]       raw;

    always_comb begin
        if (mode_a_q) begin
            period_last = (arr_a_q == '0) || (down_q && cnt_q == ONE) ||
                          (arr_a_q == ONE && cnt_q == ONE);
        end else begin
            period_last = (cnt_q == arr_a_q);
        end
        transfer = enable && period_last && pend_vld_q;

        cnt_d  = cnt_q;
        down_d = down_q;
        if (enable) begin
            if (period_last) begin
                cnt_d  = '0;
                down_d = 1'b0;
            end else if (!mode_a_q) begin
                cnt_d = cnt_q + ONE;
            end else if (down_q) begin
                cnt_d = cnt_q - ONE;
            end else if (cnt_q == arr_a_q) begin
                // Top of the triangle: turn around without repeating the peak.
                down_d = 1'b1;
                cnt_d  = cnt_q - ONE;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        arr_a_d    = arr_a_q;
        ccr_a_d    = ccr_a_q;
        pol_a_d    = pol_a_q;
        mode_a_d   = mode_a_q;
        arr_p_d    = arr_p_q;
        ccr_p_d    = ccr_p_q;
        pol_p_d    = pol_p_q;
        mode_p_d   = mode_p_q;
        pend_vld_d = pend_vld_q;
        if (transfer) begin
            arr_a_d    = arr_p_q;
            ccr_a_d    = ccr_p_q;
            pol_a_d    = pol_p_q;
            mode_a_d   = mode_p_q;
            pend_vld_d = 1'b0;
        end
        // A load in the transfer cycle lands after the old pending values were copied.
        if (load) begin
            arr_p_d    = arr;
            ccr_p_d    = ccr;
            pol_p_d    = pol;
            mode_p_d   = mode;
            pend_vld_d = 1'b1;
        end

        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (cnt_q < ccr_a_q[i*WIDTH +: WIDTH]);
        end
        pwm_d        = enable ? (raw ^ pol_a_q) : pol_a_q;
        period_end_d = enable && period_last;
        update_ack_d = transfer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            down_q       <= 1'b0;
            arr_a_q      <= '0;
            ccr_a_q      <= '0;
            pol_a_q      <= '0;
            mode_a_q     <= 1'b0;
            arr_p_q      <= '0;
            ccr_p_q      <= '0;
            pol_p_q      <= '0;
            mode_p_q     <= 1'b0;
            pend_vld_q   <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
            update_ack_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            down_q       <= down_d;
            arr_a_q      <= arr_a_d;
            ccr_a_q      <= ccr_a_d;
            pol_a_q      <= pol_a_d;
            mode_a_q     <= mode_a_d;
            arr_p_q      <= arr_p_d;
            ccr_p_q      <= ccr_p_d;
            pol_p_q      <= pol_p_d;
            mode_p_q     <= mode_p_d;
            pend_vld_q   <= pend_vld_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
            update_ack_q <= update_ack_d;
        end
    end

    assign pwm        = pwm_q;
    assign period_end = period_end_q;
    assign update_ack = update_ack_q;

endmodule
